serial_port_ctrl: RTL and testbench

//  Moore FSM that sequences the serial-to-port datapath for one frame at a time.

---
 rtl/serial_port_ctrl.sv | 88 ++++++++
 tb/tb_serial_port_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port_ctrl.sv
// Moore sequencer for the serial-to-port datapath: start bit, port field,
// count field, payload. It steps only on clkEn pulses and uses the datapath carry-outs.
package serial_port_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE_S = 3'd0,
    PORT_S = 3'd1,
    NUM_S  = 3'd2,
    LOAD_S = 3'd3,
    DATA_S = 3'd4,
    DONE_S = 3'd5
  } state_e;
endpackage

module serial_port_ctrl
  import serial_port_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clkEn,
  input  logic       serIn,
  input  logic       co1,
  input  logic       co2,
  input  logic       coD,
  output logic       shEn,
  output logic       cnt1,
  output logic       shEnD,
  output logic       cnt2,
  output logic       ldCntD,
  output logic       cntD,
  output logic       Done,
  output logic       busy,
  output logic [2:0] state
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_S;
    end else begin
      state_q <= state_d;
    end
  end

  // Each carry-out is looked at only in its own state.
  // Illegal codes fall to IDLE even when clkEn is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S: if (clkEn && !serIn) state_d = PORT_S;
      PORT_S: if (clkEn && co1)    state_d = NUM_S;
      NUM_S:  if (clkEn && co2)    state_d = LOAD_S;
      LOAD_S: if (clkEn)           state_d = DATA_S;
      DATA_S: if (clkEn && coD)    state_d = DONE_S;
      DONE_S: if (clkEn)           state_d = IDLE_S;
      default:                     state_d = IDLE_S;
    endcase
  end

  always_comb begin
    shEn   = 1'b0;
    cnt1   = 1'b0;
    shEnD  = 1'b0;
    cnt2   = 1'b0;
    ldCntD = 1'b0;
    cntD   = 1'b0;
    Done   = 1'b0;
    case (state_q)
      PORT_S: begin
        shEn = 1'b1;
        cnt1 = 1'b1;
      end
      NUM_S: begin
        shEnD = 1'b1;
        cnt2  = 1'b1;
      end
      LOAD_S:  ldCntD = 1'b1;
      DATA_S:  cntD   = 1'b1;
      DONE_S:  Done   = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE_S);
  assign state = state_q;

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Directed bench for serial_port_ctrl. A vector table covers whole frames, and
// hand-written sequences cover reset, stall and illegal-state recovery.
module tb_serial_port_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PORT = 3'd1;
  localparam logic [2:0] S_NUM  = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // {shEn, cnt1, shEnD, cnt2, ldCntD, cntD, Done, busy}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_PORT = 8'b1100_0001;
  localparam logic [7:0] O_NUM  = 8'b0011_0001;
  localparam logic [7:0] O_LOAD = 8'b0000_1001;
  localparam logic [7:0] O_DATA = 8'b0000_0101;
  localparam logic [7:0] O_DONE = 8'b0000_0011;
  localparam logic [7:0] O_ILL  = 8'b0000_0001;

  typedef struct {
    string      name;
    logic       ser;
    logic       c1;
    logic       c2;
    logic       cd;
    logic [2:0] est;
    logic [7:0] eo;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       clkEn;
  logic       serIn;
  logic       co1;
  logic       co2;
  logic       coD;
  logic       shEn;
  logic       cnt1;
  logic       shEnD;
  logic       cnt2;
  logic       ldCntD;
  logic       cntD;
  logic       Done;
  logic       busy;
  logic [2:0] state;

  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  serial_port_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .clkEn  (clkEn),
    .serIn  (serIn),
    .co1    (co1),
    .co2    (co2),
    .coD    (coD),
    .shEn   (shEn),
    .cnt1   (cnt1),
    .shEnD  (shEnD),
    .cnt2   (cnt2),
    .ldCntD (ldCntD),
    .cntD   (cntD),
    .Done   (Done),
    .busy   (busy),
    .state  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] est, input logic [7:0] eo);
    logic [7:0] ao;
    ao = {shEn, cnt1, shEnD, cnt2, ldCntD, cntD, Done, busy};
    n_vec++;
    if (state !== est || ao !== eo) begin
      n_err++;
      $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
               name, state, ao, est, eo);
    end
  endtask

  // One enabled step on a 4-clock cadence. Inputs are set on a negedge.
  // The bench samples on the negedge that ends the cadence.
  task automatic step(input logic s, input logic c1, input logic c2, input logic cd);
    @(negedge clk);
    serIn = s;
    co1   = c1;
    co2   = c2;
    coD   = cd;
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    co1   = 1'b0;
    co2   = 1'b0;
    coD   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input string name, input logic s, input logic c1, input logic c2,
                     input logic cd, input logic [2:0] est, input logic [7:0] eo);
    step(s, c1, c2, cd);
    check(name, est, eo);
  endtask

  function automatic void add(input string name, input logic s, input logic c1,
                              input logic c2, input logic cd,
                              input logic [2:0] est, input logic [7:0] eo);
    vec_t v;
    v.name = name;
    v.ser  = s;
    v.c1   = c1;
    v.c2   = c2;
    v.cd   = cd;
    v.est  = est;
    v.eo   = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    clkEn = 1'b0;
    serIn = 1'b1;
    co1   = 1'b0;
    co2   = 1'b0;
    coD   = 1'b0;

    // T2: port=10, count=0011, payload 1,0,1; stale carries must be ignored
    add("idle_hold",  1, 0, 0, 0, S_IDLE, O_IDLE);
    add("t2_start",   0, 0, 0, 0, S_PORT, O_PORT);
    add("t2_port1",   1, 0, 0, 0, S_PORT, O_PORT);
    add("t2_port0",   0, 1, 0, 0, S_NUM,  O_NUM);
    add("t2_stale1",  0, 1, 0, 0, S_NUM,  O_NUM);
    add("t2_cnt0",    0, 0, 0, 0, S_NUM,  O_NUM);
    add("t2_cnt1",    1, 0, 0, 0, S_NUM,  O_NUM);
    add("t2_cntlast", 1, 0, 1, 0, S_LOAD, O_LOAD);
    add("t2_load",    1, 0, 0, 1, S_DATA, O_DATA);
    add("t2_pay1",    1, 0, 0, 0, S_DATA, O_DATA);
    add("t2_pay0",    0, 0, 0, 0, S_DATA, O_DATA);
    add("t2_paylast", 1, 0, 0, 1, S_DONE, O_DONE);
    add("t2_done",    1, 0, 0, 0, S_IDLE, O_IDLE);
    // T4: zero count; DATA lasts one step
    add("t4_start",   0, 0, 0, 0, S_PORT, O_PORT);
    add("t4_p1",      0, 0, 0, 0, S_PORT, O_PORT);
    add("t4_p2",      1, 1, 0, 0, S_NUM,  O_NUM);
    add("t4_n1",      0, 0, 0, 0, S_NUM,  O_NUM);
    add("t4_n2",      0, 0, 0, 0, S_NUM,  O_NUM);
    add("t4_n3",      0, 0, 0, 0, S_NUM,  O_NUM);
    add("t4_n4",      0, 0, 1, 0, S_LOAD, O_LOAD);
    add("t4_load",    1, 0, 0, 0, S_DATA, O_DATA);
    add("t4_data",    1, 0, 0, 1, S_DONE, O_DONE);
    add("t4_done",    1, 0, 0, 0, S_IDLE, O_IDLE);
    add("t4_nocntd",  1, 0, 0, 1, S_IDLE, O_IDLE);
    // T5: count=1, then start bit during DONE ignored, next IDLE step starts
    add("t5_start",   0, 0, 0, 0, S_PORT, O_PORT);
    add("t5_p1",      1, 0, 0, 0, S_PORT, O_PORT);
    add("t5_p2",      1, 1, 0, 0, S_NUM,  O_NUM);
    add("t5_n1",      0, 0, 0, 0, S_NUM,  O_NUM);
    add("t5_n2",      0, 0, 0, 0, S_NUM,  O_NUM);
    add("t5_n3",      0, 0, 0, 0, S_NUM,  O_NUM);
    add("t5_n4",      1, 0, 1, 0, S_LOAD, O_LOAD);
    add("t5_load",    1, 0, 0, 0, S_DATA, O_DATA);
    add("t5_data",    0, 0, 0, 1, S_DONE, O_DONE);
    add("t5_done_s0", 0, 0, 0, 0, S_IDLE, O_IDLE);
    add("t5_restart", 0, 0, 0, 0, S_PORT, O_PORT);
    add("t5_p2b",     1, 1, 0, 0, S_NUM,  O_NUM);

    repeat (3) @(negedge clk);
    check("reset_active", S_IDLE, O_IDLE);
    rst = 1'b1;
    @(negedge clk);
    check("reset_release", S_IDLE, O_IDLE);

    foreach (tbl[i]) begin
      run(tbl[i].name, tbl[i].ser, tbl[i].c1, tbl[i].c2, tbl[i].cd, tbl[i].est, tbl[i].eo);
    end

    // T3: stall mid-NUM with carries and line activity present
    co2 = 1'b1;
    coD = 1'b1;
    co1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      serIn = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t3_stall", S_NUM, O_NUM);
    end
    co1 = 1'b0;
    co2 = 1'b0;
    coD = 1'b0;
    run("t3_n2",   0, 0, 0, 0, S_NUM,  O_NUM);
    run("t3_n3",   0, 0, 0, 0, S_NUM,  O_NUM);
    run("t3_n4",   0, 0, 1, 0, S_LOAD, O_LOAD);
    run("t3_load", 1, 0, 0, 0, S_DATA, O_DATA);
    run("t3_data", 1, 0, 0, 1, S_DONE, O_DONE);
    run("t3_done", 1, 0, 0, 0, S_IDLE, O_IDLE);

    // T1: reset mid-frame in DATA, asynchronously
    run("t1_start", 0, 0, 0, 0, S_PORT, O_PORT);
    run("t1_p2",    0, 1, 0, 0, S_NUM,  O_NUM);
    run("t1_n4",    0, 0, 1, 0, S_LOAD, O_LOAD);
    run("t1_load",  1, 0, 0, 0, S_DATA, O_DATA);
    #2;
    rst = 1'b0;
    #1;
    check("t1_async_rst", S_IDLE, O_IDLE);
    @(negedge clk);
    serIn = 1'b0;
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    serIn = 1'b1;
    check("t1_rst_hold", S_IDLE, O_IDLE);
    rst = 1'b1;
    run("t1_idle", 1, 0, 0, 0, S_IDLE, O_IDLE);

    // T6: illegal code recovers with clkEn low
    @(negedge clk);
    force dut.state_q = serial_port_ctrl_pkg::state_e'(3'b110);
    #1;
    check("t6_forced", 3'd6, O_ILL);
    release dut.state_q;
    @(negedge clk);
    check("t6_recover", S_IDLE, O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
